uart_tx_frame: RTL and testbench

Parametrised successor to the fixed 8N1 UART transmitter used on the I2C/UART bridge path. It adds configurable data width, a runtime-selectable parity mode, 1 or 2 stop bits, and a small input FIFO with a valid/ready handshake. Back-to-back bytes are sent with no idle gap between frames. It sits between the byte-producing logic (I2C capture, debug formatter) and the board TX pin.

---
 rtl/uart_tx_frame.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter with an input FIFO, runtime parity mode and 1 or 2 stop bits.
// Defining UART_TX_BREAK_EN adds a break_req input and a line-break (BREAK) state.
module uart_tx_frame #(
    parameter int CLK_FREQ   = 84_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          valid,
    output logic                          ready,
    input  logic [1:0]                    parity_mode,
`ifdef UART_TX_BREAK_EN
    input  logic                          break_req,
`endif
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int TMR_W      = $clog2(BIT_PERIOD);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = PTR_W + 1;
    localparam int IDX_W      = 4;

    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(BIT_PERIOD - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
`ifdef UART_TX_BREAK_EN
        S_BREAK,
`endif
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;

    assign ready      = (fifo_level != LVL_FULL);
    assign fifo_empty = (fifo_level == '0);
    assign push       = valid && ready;

    // NOTE: the storage array carries no reset; emptiness is defined by the
    // pointers and level alone, so flushing them is enough.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t               state;
    state_t               state_n;
    logic [TMR_W-1:0]     bit_timer;
    logic [TMR_W-1:0]     timer_n;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     idx_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 par_bit;
    logic                 par_bit_n;
    logic                 par_en;
    logic                 par_en_n;
    logic                 tx_n;
    logic                 bit_end;
    logic                 dispatch;

    assign bit_end = (bit_timer == TMR_LAST);
    assign busy    = (state != S_IDLE) || !fifo_empty;

`ifdef UART_TX_BREAK_EN
    logic [IDX_W-1:0] brk_last;
    // Break spans start + data + optional parity + stop bits + one extra bit.
    assign brk_last = par_en ? IDX_W'(DATA_BITS + STOP_BITS + 2)
                             : IDX_W'(DATA_BITS + STOP_BITS + 1);
`endif

    function automatic logic parity_of(input logic [1:0] mode,
                                       input logic [DATA_BITS-1:0] word);
        case (mode)
            2'd1:    return ~^word;
            2'd2:    return ^word;
            default: return 1'b1;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        timer_n   = bit_end ? '0 : bit_timer + TMR_W'(1);
        idx_n     = bit_idx;
        shreg_n   = shreg;
        par_bit_n = par_bit;
        par_en_n  = par_en;
        pop       = 1'b0;
        dispatch  = 1'b0;

        case (state)
            S_IDLE: begin
                timer_n  = '0;
                dispatch = 1'b1;
            end
            S_START: begin
                if (bit_end) state_n = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        idx_n   = '0;
                        state_n = par_en ? S_PARITY : S_STOP;
                    end else begin
                        idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_n = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        idx_n    = '0;
                        state_n  = S_IDLE;
                        dispatch = 1'b1;
                    end else begin
                        idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                if (bit_end) begin
                    if (bit_idx == brk_last) begin
                        idx_n   = '0;
                        state_n = S_STOP;
                    end else begin
                        idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase

        // Launch the next frame straight from IDLE or from the last stop bit.
        if (dispatch) begin
`ifdef UART_TX_BREAK_EN
            if (break_req) begin
                state_n  = S_BREAK;
                par_en_n = (parity_mode != 2'd0);
            end else
`endif
            if (!fifo_empty) begin
                pop       = 1'b1;
                state_n   = S_START;
                shreg_n   = mem[rd_ptr];
                par_en_n  = (parity_mode != 2'd0);
                par_bit_n = parity_of(parity_mode, mem[rd_ptr]);
            end
        end

        if (state_n != state) begin
            timer_n = '0;
        end

        // tx is registered from the next-state view so it changes on the
        // same edge as the state it belongs to.
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = par_bit_n;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  tx_n = 1'b0;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            par_en    <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_n;
            bit_timer <= timer_n;
            bit_idx   <= idx_n;
            shreg     <= shreg_n;
            par_bit   <= par_bit_n;
            par_en    <= par_en_n;
            tx        <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a driver queues expected frames, a monitor
// decodes tx cycle by cycle against a bit-list model built from the frame rules.
module tb_uart_tx_frame;

    localparam int BIT_CYC = 16;

    typedef bit bit_q_t[$];
    typedef struct {
        logic [8:0] data;
        logic [1:0] mode;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = '0;
    logic       valid = 1'b0;
    logic [1:0] parity_mode = '0;
    logic       break_req = 1'b0;
    logic       ready, tx, busy;
    logic [2:0] fifo_level;

    logic [4:0] data2 = '0;
    logic       valid2 = 1'b0;
    logic [1:0] parity_mode2 = '0;
    logic       ready2, tx2, busy2;
    logic [1:0] fifo_level2;

    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     nframes = 0;
    logic   mon_abort = 1'b0;
    frame_t exp_q[$];

    uart_tx_frame #(
        .CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
        .parity_mode(parity_mode),
`ifdef UART_TX_BREAK_EN
        .break_req(break_req),
`endif
        .tx(tx), .busy(busy), .fifo_level(fifo_level)
    );

    uart_tx_frame #(
        .CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(2)
    ) dut2 (
        .clk(clk), .rst(rst), .data(data2), .valid(valid2), .ready(ready2),
        .parity_mode(parity_mode2),
`ifdef UART_TX_BREAK_EN
        .break_req(1'b0),
`endif
        .tx(tx2), .busy(busy2), .fifo_level(fifo_level2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Line bits of one frame: start, data LSB first, optional parity, stop bits.
    function automatic void build_frame(input logic [8:0] d, input logic [1:0] m,
                                        input int nbits, input int nstop,
                                        output bit_q_t bits);
        int ones = 0;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        case (m)
            2'd1:    bits.push_back(ones % 2 == 0);
            2'd2:    bits.push_back(ones % 2 == 1);
            2'd3:    bits.push_back(1'b1);
            default: ;
        endcase
        for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
    endfunction

    task automatic push_word(input logic [7:0] d, input logic [1:0] m, output int acc_cyc);
        int n = 0;
        frame_t f;
        data = d;
        valid = 1'b1;
        parity_mode = m;
        acc_cyc = -1;
        while (acc_cyc < 0) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                f.data = {1'b0, d};
                f.mode = m;
                exp_q.push_back(f);
            end else begin
                n++;
                if (n > 2000) begin
                    check("ready within push budget", 32'(ready), 1);
                    break;
                end
            end
        end
        valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy_low(output int c);
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy falls within budget", 32'(busy), 0);
        c = cyc;
    endtask

    task automatic dut2_frame(input logic [4:0] d, input logic [1:0] m);
        bit_q_t bits;
        int bad = 0;
        int len;
        build_frame({4'b0, d}, m, 5, 2, bits);
        len = bits.size() * BIT_CYC;
        check("dut2 ready before push", 32'(ready2), 1);
        parity_mode2 = m;
        data2 = d;
        valid2 = 1'b1;
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        check("dut2 tx high on accept edge", 32'(tx2), 1);
        for (int n = 0; n < len; n++) begin
            @(posedge clk);
            #1;
            if (tx2 !== bits[n / BIT_CYC]) bad++;
        end
        check($sformatf("dut2 frame %02h mode %0d bit errors", d, m), bad, 0);
        @(posedge clk);
        #1;
        check("dut2 busy after frame", 32'(busy2), 0);
        check("dut2 tx idle after frame", 32'(tx2), 1);
    endtask

    // Monitor: on each start bit, pop the expected frame and check every cycle.
    initial begin : monitor
        frame_t e;
        bit_q_t bits;
        int     bad;
        logic   aborted;
        forever begin
            @(negedge clk);
            if (!mon_abort && tx === 1'b0) begin
                check("expected frame queued at start bit", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    build_frame(e.data, e.mode, 8, 1, bits);
                    aborted = 1'b0;
                    for (int b = 0; b < bits.size() && !aborted; b++) begin
                        bad = 0;
                        for (int k = 0; k < BIT_CYC; k++) begin
                            if (b != 0 || k != 0) begin
                                @(negedge clk);
                                if (mon_abort) begin
                                    aborted = 1'b1;
                                    break;
                                end
                            end
                            if (tx !== bits[b]) bad++;
                        end
                        if (!aborted)
                            check($sformatf("frame %0d (%02h mode %0d) bit %0d errors",
                                            nframes, e.data, e.mode, b), bad, 0);
                    end
                    nframes++;
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c0, c, lows;
        logic [1:0] m;
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset tx", 32'(tx), 1);
        check("reset ready", 32'(ready), 1);
        check("reset busy", 32'(busy), 0);
        check("reset fifo_level", 32'(fifo_level), 0);
        check("reset dut2 fifo_level", 32'(fifo_level2), 0);

        // Single 8N1 frame: start one cycle after accept, 160-cycle frame.
        push_word(8'h55, 2'd0, c0);
        check("tx still high on accept edge", 32'(tx), 1);
        @(posedge clk);
        #1;
        check("start bit one cycle after accept", 32'(tx), 0);
        wait_busy_low(c);
        check("8N1 busy span", c - c0, 161);

        // Parity frames, with a mid-frame mode change that must be ignored.
        push_word(8'h07, 2'd2, c0);
        wait_busy_low(c);
        check("even parity busy span", c - c0, 177);
        push_word(8'h07, 2'd1, c0);
        idle_cycles(20);
        parity_mode = 2'd2;
        wait_busy_low(c);
        check("odd parity busy span", c - c0, 177);
        push_word(8'h00, 2'd3, c0);
        wait_busy_low(c);
        check("mark parity busy span", c - c0, 177);

        // Burst of six: FIFO fills, sixth word waits for a pop, frames contiguous.
        push_word(8'hA1, 2'd0, c0);
        for (int i = 0; i < 4; i++) push_word(8'(8'hB0 + i), 2'd0, c);
        check("fifo_level when full", 32'(fifo_level), 4);
        check("ready when full", 32'(ready), 0);
        push_word(8'h3C, 2'd0, c);
        check("sixth word accept cycle", c - c0, 162);
        wait_busy_low(c);
        check("burst busy span", c - c0, 961);

        // Second configuration: 5 data bits, 2 stop bits.
        dut2_frame(5'h1F, 2'd0);
        dut2_frame(5'($urandom), 2'd2);

        // Reset mid-frame with two words queued.
        push_word(8'h81, 2'd0, c0);
        push_word(8'h42, 2'd0, c);
        push_word(8'h24, 2'd0, c);
        while (cyc < c0 + 50) begin
            @(posedge clk);
            #1;
        end
        mon_abort = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("tx after mid-frame reset", 32'(tx), 1);
        check("fifo_level after mid-frame reset", 32'(fifo_level), 0);
        check("busy after mid-frame reset", 32'(busy), 0);
        check("ready after mid-frame reset", 32'(ready), 1);
        exp_q.delete();
        lows = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
        check("tx low cycles after reset", lows, 0);
        mon_abort = 1'b0;

`ifdef UART_TX_BREAK_EN
        // Break from IDLE with a word pushed on the same edge.
        mon_abort = 1'b1;
        break_req = 1'b1;
        push_word(8'h5A, 2'd0, c0);
        break_req = 1'b0;
        check("busy during break", 32'(busy), 1);
        lows = 0;
        for (int i = 0; i < 11 * BIT_CYC; i++) begin
            if (tx !== 1'b0) lows++;
            @(posedge clk);
            #1;
        end
        check("break low-span errors", lows, 0);
        lows = 0;
        for (int i = 0; i < BIT_CYC; i++) begin
            if (tx !== 1'b1) lows++;
            if (i < BIT_CYC - 1) begin
                @(posedge clk);
                #1;
            end
        end
        check("mark after break errors", lows, 0);
        mon_abort = 1'b0;
        wait_busy_low(c);
`endif

        // Randomised phases: constant parity per phase, random words and gaps.
        for (int p = 0; p < 8; p++) begin
            m = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                push_word(8'($urandom), m, c);
                if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 200));
            end
            wait_busy_low(c);
        end

        idle_cycles(5);
        check("expected queue drained", exp_q.size(), 0);
        check("tx idle at end", 32'(tx), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
